// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared CPU constants used by the GPR write-back arbiter and its result FIFO.
package gpr_wb_arbiter_pkg;

    localparam int unsigned GPR_AW        = 5;
    localparam int unsigned GPR_DW        = 32;
    localparam int unsigned WB_FIFO_DEPTH = 4;

    localparam logic [GPR_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/gpr_wb_arbiter_fifo.sv
// Circular buffer of MDU results with per-entry live bits, kill-by-address and
// per-entry address match vectors for the decode hazard check.
module gpr_wb_arbiter_fifo
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH,
    parameter int unsigned AW    = GPR_AW,
    parameter int unsigned DW    = GPR_DW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_push_live,
    input  logic [AW-1:0]              i_push_addr,
    input  logic [DW-1:0]              i_push_data,
    input  logic                       i_pop,
    input  logic                       i_kill_en,
    input  logic [AW-1:0]              i_kill_addr,
    input  logic [AW-1:0]              i_cmp1_addr,
    input  logic [AW-1:0]              i_cmp2_addr,
    output logic                       o_head_occ,
    output logic                       o_head_live,
    output logic [AW-1:0]              o_head_addr,
    output logic [DW-1:0]              o_head_data,
    output logic                       o_full,
    output logic [DEPTH-1:0]           o_match1,
    output logic [DEPTH-1:0]           o_match2,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Kill first, then push/pop; a pop clears its live bit so free slots never match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_live  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i_kill_en && (r_addr[i] == i_kill_addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (i_push) begin
                r_addr[r_wptr] <= i_push_addr;
                r_data[r_wptr] <= i_push_data;
                r_live[r_wptr] <= i_push_live;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (i_pop) begin
                r_live[r_rptr] <= 1'b0;
                r_rptr         <= r_rptr + PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_comb begin
        o_match1 = '0;
        o_match2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_match1[i] = r_live[i] && (r_addr[i] == i_cmp1_addr);
            o_match2[i] = r_live[i] && (r_addr[i] == i_cmp2_addr);
        end
    end

    assign o_head_occ  = (r_count != '0);
    assign o_head_live = r_live[r_rptr];
    assign o_head_addr = r_addr[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_count     = r_count;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Sole driver of the GPR write port: pipeline write-back wins, queued MDU results
// drain into idle cycles, and decode gets hazard flags for pending writes.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH,
    parameter int unsigned AW    = GPR_AW,
    parameter int unsigned DW    = GPR_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_pipe_we,
    input  logic [AW-1:0]          i_pipe_addr,
    input  logic [DW-1:0]          i_pipe_data,
    input  logic                   i_md_valid,
    output logic                   o_md_ready,
    input  logic [AW-1:0]          i_md_addr,
    input  logic [DW-1:0]          i_md_data,
    output logic                   o_rf_we,
    output logic [AW-1:0]          o_rf_addr,
    output logic [DW-1:0]          o_rf_data,
    input  logic [AW-1:0]          i_rs1_q,
    input  logic [AW-1:0]          i_rs2_q,
    output logic                   o_hazard_rs1,
    output logic                   o_hazard_rs2,
    output logic [$clog2(DEPTH):0] o_fifo_count
);

    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic             w_pipe_wr;
    logic             w_push;
    logic             w_push_live;
    logic             w_pop;
    logic             w_full;
    logic             w_head_occ;
    logic             w_head_live;
    logic [AW-1:0]    w_head_addr;
    logic [DW-1:0]    w_head_data;
    logic [DEPTH-1:0] w_match1;
    logic [DEPTH-1:0] w_match2;
    logic             r_rf_we;
    logic [AW-1:0]    r_rf_addr;
    logic [DW-1:0]    r_rf_data;

    // The pipe write is always younger, so it also kills matching queued MDU writes.
    assign w_pipe_wr   = i_pipe_we && (i_pipe_addr != ZERO);
    assign o_md_ready  = !w_full;
    assign w_push      = i_md_valid && o_md_ready && (i_md_addr != ZERO);
    assign w_push_live = !(w_pipe_wr && (i_md_addr == i_pipe_addr));
    assign w_pop       = !w_pipe_wr && w_head_occ;

    gpr_wb_arbiter_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_live (w_push_live),
        .i_push_addr (i_md_addr),
        .i_push_data (i_md_data),
        .i_pop       (w_pop),
        .i_kill_en   (w_pipe_wr),
        .i_kill_addr (i_pipe_addr),
        .i_cmp1_addr (i_rs1_q),
        .i_cmp2_addr (i_rs2_q),
        .o_head_occ  (w_head_occ),
        .o_head_live (w_head_live),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_match1    (w_match1),
        .o_match2    (w_match2),
        .o_count     (o_fifo_count)
    );

    // A killed head pops silently: write enable drops and address/data hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else if (w_pipe_wr) begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= i_pipe_addr;
            r_rf_data <= i_pipe_data;
        end else if (w_pop && w_head_live) begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= w_head_addr;
            r_rf_data <= w_head_data;
        end else begin
            r_rf_we   <= 1'b0;
        end
    end

    assign o_rf_we   = r_rf_we;
    assign o_rf_addr = r_rf_addr;
    assign o_rf_data = r_rf_data;

    // The register file updates at end of cycle, so the write on rf_* is still pending.
    assign o_hazard_rs1 = (i_rs1_q != ZERO) &&
                          ((|w_match1) || (r_rf_we && (r_rf_addr == i_rs1_q)));
    assign o_hazard_rs2 = (i_rs2_q != ZERO) &&
                          ((|w_match2) || (r_rf_we && (r_rf_addr == i_rs2_q)));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: reset, pipe priority, MDU drain, back-pressure,
// WAW kill and hazard flags, all against hand-computed values.
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pipe_we    (pipe_we),
        .i_pipe_addr  (pipe_addr),
        .i_pipe_data  (pipe_data),
        .i_md_valid   (md_valid),
        .o_md_ready   (md_ready),
        .i_md_addr    (md_addr),
        .i_md_data    (md_data),
        .o_rf_we      (rf_we),
        .o_rf_addr    (rf_addr),
        .o_rf_data    (rf_data),
        .i_rs1_q      (rs1_q),
        .i_rs2_q      (rs2_q),
        .o_hazard_rs1 (hazard_rs1),
        .o_hazard_rs2 (hazard_rs2),
        .o_fifo_count (fifo_count)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert (fifo_count <= 3'd4)
                else $error("FAIL fifo_bound got=%0d want<=4", fifo_count);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic [2:0] cnt);
        chk({tag, "_we"},  32'(rf_we), 32'(we));
        chk({tag, "_addr"}, 32'(rf_addr), 32'(a));
        chk({tag, "_data"}, rf_data, d);
        chk({tag, "_cnt"}, 32'(fifo_count), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
        md_valid = 1'b1; md_addr = 5'd3; md_data = 32'h33; rs1_q = '0; rs2_q = '0;

        // Reset with md_valid asserted: nothing may be queued
        tick(); tick();
        chk_rf("rst", 1'b0, 5'd0, 32'h0, 3'd0);
        chk("rst_ready", 32'(md_ready), 32'd1);
        rst_n = 1'b1; md_valid = 1'b0;
        tick();
        chk_rf("idle", 1'b0, 5'd0, 32'h0, 3'd0);

        // Pipe only, then a pipe write to $zero
        pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
        tick();
        chk_rf("pipe", 1'b1, 5'd5, 32'hDEADBEEF, 3'd0);
        pipe_we = 1'b0;
        tick();
        chk_rf("pipe_off", 1'b0, 5'd5, 32'hDEADBEEF, 3'd0);
        pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h1234;
        tick();
        chk_rf("pipe_r0", 1'b0, 5'd5, 32'hDEADBEEF, 3'd0);
        pipe_we = 1'b0;

        // MDU pushes under pipe contention, then drain in order
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1; pipe_addr = 5'(20 + i); pipe_data = 32'(100 + i);
            md_valid = (i < 3); md_addr = 5'(8 + i); md_data = 32'(i + 1);
            tick();
            chk_rf($sformatf("cont%0d", i), 1'b1, 5'(20 + i), 32'(100 + i),
                   3'((i < 3) ? i + 1 : 3));
        end
        pipe_we = 1'b0; md_valid = 1'b0;
        tick(); chk_rf("drain0", 1'b1, 5'd8,  32'd1, 3'd2);
        tick(); chk_rf("drain1", 1'b1, 5'd9,  32'd2, 3'd1);
        tick(); chk_rf("drain2", 1'b1, 5'd10, 32'd3, 3'd0);
        tick(); chk_rf("drain3", 1'b0, 5'd10, 32'd3, 3'd0);

        // Fill to full under pipe contention, 5th entry waits for a free slot
        pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            md_valid = 1'b1; md_addr = 5'(11 + i); md_data = 32'(8'h11 * (i + 1));
            tick();
            chk($sformatf("fill%0d_cnt", i), 32'(fifo_count), 32'(i + 1));
        end
        chk("full_ready", 32'(md_ready), 32'd0);
        md_addr = 5'd15; md_data = 32'h55;
        tick();
        chk("full_hold_cnt", 32'(fifo_count), 32'd4);
        chk("full_hold_ready", 32'(md_ready), 32'd0);
        pipe_we = 1'b0;
        tick();
        chk_rf("bp_pop0", 1'b1, 5'd11, 32'h11, 3'd3);
        chk("bp_ready", 32'(md_ready), 32'd1);
        tick();
        chk_rf("bp_pop1", 1'b1, 5'd12, 32'h22, 3'd3);
        md_valid = 1'b0;
        tick(); chk_rf("bp_pop2", 1'b1, 5'd13, 32'h33, 3'd2);
        tick(); chk_rf("bp_pop3", 1'b1, 5'd14, 32'h44, 3'd1);
        tick(); chk_rf("bp_pop4", 1'b1, 5'd15, 32'h55, 3'd0);

        // WAW: queued r12 is killed by a younger pipe write to r12
        pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h0;
        md_valid = 1'b1; md_addr = 5'd12; md_data = 32'hAAAA;
        tick();
        chk_rf("waw_q", 1'b1, 5'd20, 32'h0, 3'd1);
        md_valid = 1'b0; pipe_addr = 5'd12; pipe_data = 32'hBBBB;
        tick();
        chk_rf("waw_pipe", 1'b1, 5'd12, 32'hBBBB, 3'd1);
        pipe_we = 1'b0; rs1_q = 5'd12;
        tick();
        chk_rf("waw_noop", 1'b0, 5'd12, 32'hBBBB, 3'd0);
        chk("waw_haz", 32'(hazard_rs1), 32'd0);
        tick();
        chk_rf("waw_after", 1'b0, 5'd12, 32'hBBBB, 3'd0);

        // Same-cycle push and pipe write to r13: pushed already killed
        pipe_we = 1'b1; pipe_addr = 5'd13; pipe_data = 32'hCC;
        md_valid = 1'b1; md_addr = 5'd13; md_data = 32'hDD;
        tick();
        chk_rf("waw_same", 1'b1, 5'd13, 32'hCC, 3'd1);
        pipe_we = 1'b0; md_valid = 1'b0;
        tick();
        chk_rf("waw_same_pop", 1'b0, 5'd13, 32'hCC, 3'd0);

        // MDU result to $zero: handshake completes, nothing queued
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hEE;
        #1 chk("md_r0_ready", 32'(md_ready), 32'd1);
        tick();
        md_valid = 1'b0;
        chk_rf("md_r0", 1'b0, 5'd13, 32'hCC, 3'd0);

        // Hazards: queued r7, then r7 on rf_*, then cleared
        pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h0;
        md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h77;
        tick();
        md_valid = 1'b0; rs1_q = 5'd7; rs2_q = 5'd6;
        #1;
        chk("haz_q_rs1", 32'(hazard_rs1), 32'd1);
        chk("haz_q_rs2", 32'(hazard_rs2), 32'd0);
        pipe_we = 1'b0;
        tick();
        chk_rf("haz_wr", 1'b1, 5'd7, 32'h77, 3'd0);
        chk("haz_wr_rs1", 32'(hazard_rs1), 32'd1);
        tick();
        chk("haz_done_rs1", 32'(hazard_rs1), 32'd0);
        rs1_q = 5'd0; rs2_q = 5'd20;
        #1;
        chk("haz_r0", 32'(hazard_rs1), 32'd0);
        chk("haz_stale_rs2", 32'(hazard_rs2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
